mem_stage: RTL and testbench

- Pipeline memory stage that sits directly downstream of the execute stage.
- Contains the EXE/MEM pipeline register, which latches the ALU result, store value and control bits.
- Performs the data-memory load or store with a configurable multi-cycle latency, and freezes upstream stages while an access is in flight.
- Drives the MEM/WB register, and exports the MEM-stage ALU result back to the execute forwarding muxes.

---
 rtl/mem_stage_pkg.sv | 10 +
 rtl/mem_stage_data_memory.sv | 21 ++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, memory map and default latency for the memory stage.
package mem_stage_pkg;
  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int DMEM_BASE         = 1024;
  localparam int DMEM_DEPTH        = 256;
  localparam int MEM_LATENCY       = 2;
  // Latency counter width; covers MEM_LATENCY up to 15.
  localparam int CNT_W             = 4;
endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-indexed data memory: synchronous write, combinational read, no reset.
module data_memory #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH    = 256,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       idx,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata
);
  logic [WORD_LEN-1:0] mem [DEPTH];

  // Single-port write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EXE/MEM register, multi-cycle data-memory access
// with upstream freeze, MEM/WB register and forwarding taps.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WORD_LEN     = mem_stage_pkg::WORD_LEN,
  parameter int REG_ADDR_LEN = mem_stage_pkg::REG_FILE_ADDR_LEN,
  parameter int DMEM_DEPTH   = mem_stage_pkg::DMEM_DEPTH,
  parameter int DMEM_BASE    = mem_stage_pkg::DMEM_BASE,
  parameter int MEM_LATENCY  = mem_stage_pkg::MEM_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exe_valid,
  input  logic                    WB_EN_in,
  input  logic                    MEM_R_EN_in,
  input  logic                    MEM_W_EN_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic [WORD_LEN-1:0]     ALU_res_in,
  input  logic [WORD_LEN-1:0]     ST_value_in,
  output logic                    mem_stall,
  output logic [WORD_LEN-1:0]     ALU_res_MEM,
  output logic                    WB_EN_MEM,
  output logic [REG_ADDR_LEN-1:0] dest_MEM,
  output logic                    MEM_R_EN_MEM,
  output logic                    wb_valid,
  output logic                    WB_EN_out,
  output logic                    MEM_R_EN_out,
  output logic [REG_ADDR_LEN-1:0] dest_out,
  output logic [WORD_LEN-1:0]     ALU_res_out,
  output logic [WORD_LEN-1:0]     mem_data_out,
  output logic                    mem_err
);
  localparam int AW = $clog2(DMEM_DEPTH);

  logic [CNT_W-1:0]    cnt_p0;
  logic                vld_p0;
  logic                w_en_p0;
  logic [WORD_LEN-1:0] st_val_p0;
  logic [WORD_LEN-1:0] offset;
  logic [AW-1:0]       word_idx;
  logic [WORD_LEN-1:0] rdata;
  logic                fault;
  logic                done;
  logic                mem_we;

  // Out of range (below base or past the last word) or not word aligned.
  function automatic logic addr_fault(input logic [WORD_LEN-1:0] addr);
    logic [WORD_LEN-1:0] off;
    off = addr - WORD_LEN'(DMEM_BASE);
    return (addr < WORD_LEN'(DMEM_BASE)) ||
           ((off >> 2) >= WORD_LEN'(DMEM_DEPTH)) ||
           (addr[1:0] != 2'b00);
  endfunction

  assign mem_stall = (cnt_p0 != '0);
  assign done      = (cnt_p0 == '0);
  assign offset    = ALU_res_MEM - WORD_LEN'(DMEM_BASE);
  assign word_idx  = AW'(offset >> 2);
  assign fault     = addr_fault(ALU_res_MEM);
  // Store commits only on its completion edge, never on a faulting address.
  assign mem_we    = w_en_p0 & done & ~fault;

  data_memory #(.WORD_LEN(WORD_LEN), .DEPTH(DMEM_DEPTH)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (word_idx),
    .wdata (st_val_p0),
    .rdata (rdata)
  );

  // ---- EXE/MEM boundary ----
  // Latch the execute result when idle; count down and hold while an access is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0       <= '0;
      vld_p0       <= 1'b0;
      WB_EN_MEM    <= 1'b0;
      MEM_R_EN_MEM <= 1'b0;
      w_en_p0      <= 1'b0;
      dest_MEM     <= '0;
      ALU_res_MEM  <= '0;
      st_val_p0    <= '0;
    end else if (!done) begin
      cnt_p0 <= cnt_p0 - CNT_W'(1);
    end else begin
      vld_p0       <= exe_valid;
      WB_EN_MEM    <= exe_valid & WB_EN_in;
      MEM_R_EN_MEM <= exe_valid & MEM_R_EN_in & ~MEM_W_EN_in;
      w_en_p0      <= exe_valid & MEM_W_EN_in;
      dest_MEM     <= exe_valid ? dest_in     : '0;
      ALU_res_MEM  <= exe_valid ? ALU_res_in  : '0;
      st_val_p0    <= exe_valid ? ST_value_in : '0;
      cnt_p0       <= (exe_valid & (MEM_R_EN_in | MEM_W_EN_in)) ?
                      CNT_W'(MEM_LATENCY - 1) : '0;
    end
  end

  // ---- MEM/WB boundary ----
  // Forward the completed op to writeback; emit a bubble on every waiting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || !done) begin
      wb_valid     <= 1'b0;
      WB_EN_out    <= 1'b0;
      MEM_R_EN_out <= 1'b0;
      dest_out     <= '0;
      ALU_res_out  <= '0;
      mem_data_out <= '0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid     <= vld_p0;
      WB_EN_out    <= WB_EN_MEM;
      MEM_R_EN_out <= MEM_R_EN_MEM;
      dest_out     <= dest_MEM;
      ALU_res_out  <= ALU_res_MEM;
      mem_data_out <= (MEM_R_EN_MEM & ~fault) ? rdata : '0;
      mem_err      <= (MEM_R_EN_MEM | w_en_p0) & fault;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: latency-2 and latency-4 instances share one
// stimulus bundle; a negedge monitor pops expected MEM/WB entries.
module tb_mem_stage;
  logic        clk;
  logic        rst;
  logic        ev;
  logic        sel;
  logic        wb_en, rd_en, wr_en;
  logic [4:0]  dest;
  logic [31:0] alu, stv;

  logic        stall2, fwb2, frd2, wbv2, wbo2, rdo2, err2;
  logic [4:0]  fdest2, dout2;
  logic [31:0] falu2, aluo2, data2;
  logic        stall4, fwb4, frd4, wbv4, wbo4, rdo4, err4;
  logic [4:0]  fdest4, dout4;
  logic [31:0] falu4, aluo4, data4;

  logic        f_stall, f_wb, f_rd;
  logic [4:0]  f_dest;
  logic [31:0] f_alu;

  typedef struct {
    logic        wb;
    logic        rd;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  mem_stage dut2 (
    .clk(clk), .rst(rst), .exe_valid(ev & ~sel), .WB_EN_in(wb_en),
    .MEM_R_EN_in(rd_en), .MEM_W_EN_in(wr_en), .dest_in(dest),
    .ALU_res_in(alu), .ST_value_in(stv), .mem_stall(stall2),
    .ALU_res_MEM(falu2), .WB_EN_MEM(fwb2), .dest_MEM(fdest2),
    .MEM_R_EN_MEM(frd2), .wb_valid(wbv2), .WB_EN_out(wbo2),
    .MEM_R_EN_out(rdo2), .dest_out(dout2), .ALU_res_out(aluo2),
    .mem_data_out(data2), .mem_err(err2)
  );

  mem_stage #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .exe_valid(ev & sel), .WB_EN_in(wb_en),
    .MEM_R_EN_in(rd_en), .MEM_W_EN_in(wr_en), .dest_in(dest),
    .ALU_res_in(alu), .ST_value_in(stv), .mem_stall(stall4),
    .ALU_res_MEM(falu4), .WB_EN_MEM(fwb4), .dest_MEM(fdest4),
    .MEM_R_EN_MEM(frd4), .wb_valid(wbv4), .WB_EN_out(wbo4),
    .MEM_R_EN_out(rdo4), .dest_out(dout4), .ALU_res_out(aluo4),
    .mem_data_out(data4), .mem_err(err4)
  );

  assign f_stall = sel ? stall4 : stall2;
  assign f_wb    = sel ? fwb4   : fwb2;
  assign f_rd    = sel ? frd4   : frd2;
  assign f_dest  = sel ? fdest4 : fdest2;
  assign f_alu   = sel ? falu4  : falu2;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
  endtask

  task automatic check_entry(input string tag, input exp_t e, input logic wb, input logic rd,
                             input logic [4:0] d, input logic [31:0] a,
                             input logic [31:0] dat, input logic er);
    chk({tag, "_wb_en"},   32'(wb),  32'(e.wb));
    chk({tag, "_rd_en"},   32'(rd),  32'(e.rd));
    chk({tag, "_dest"},    32'(d),   32'(e.dest));
    chk({tag, "_alu"},     a,        e.alu);
    chk({tag, "_data"},    dat,      e.data);
    chk({tag, "_err"},     32'(er),  32'(e.err));
    chk({tag, "_latency"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor: every valid MEM/WB entry must match the oldest expectation.
  always @(negedge clk) begin
    if (wbv2) begin
      if (q2.size() == 0) chk("unexpected_wb_lat2", 32'(wbv2), 32'd0);
      else begin
        e2 = q2.pop_front();
        check_entry("lat2", e2, wbo2, rdo2, dout2, aluo2, data2, err2);
      end
    end
    if (wbv4) begin
      if (q4.size() == 0) chk("unexpected_wb_lat4", 32'(wbv4), 32'd0);
      else begin
        e4 = q4.pop_front();
        check_entry("lat4", e4, wbo4, rdo4, dout4, aluo4, data4, err4);
      end
    end
  end

  task automatic idle(input int n);
    ev = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one instruction, hold it while stalled, and queue its expected writeback.
  task automatic issue(input logic wb, input logic r, input logic w, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_stall);
    exp_t e;
    int   n;
    int   lat;
    lat    = sel ? 4 : 2;
    e.wb   = wb;
    e.rd   = r & ~w;
    e.dest = d;
    e.alu  = a;
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc + 1 + ((r | w) ? lat : 1);
    if (sel) q4.push_back(e); else q2.push_back(e);
    ev = 1'b1; wb_en = wb; rd_en = r; wr_en = w; dest = d; alu = a; stv = s;
    @(posedge clk); #1;
    chk("fwd_alu",  f_alu,      a);
    chk("fwd_dest", 32'(f_dest), 32'(d));
    chk("fwd_wb",   32'(f_wb),   32'(wb));
    chk("fwd_rd",   32'(f_rd),   32'(r & ~w));
    n = 0;
    while (f_stall && n < 40) begin
      n++;
      @(posedge clk); #1;
      chk("fwd_hold_alu", f_alu, a);
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    ev = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall2"}, 32'(stall2), 32'd0);
    chk({tag, "_stall4"}, 32'(stall4), 32'd0);
    chk({tag, "_outs2"}, 32'(|{falu2, fwb2, fdest2, frd2, wbv2, wbo2, rdo2,
                               dout2, aluo2, data2, err2}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; ev = 1'b0; sel = 1'b0;
    wb_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0; dest = '0; alu = '0; stv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_zero("bubble");
    end

    // Stores and load at the base region
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'd1024, 32'h1111_1111, 32'd0, 1'b0, 1);
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'd1028, 32'hDEAD_BEEF, 32'd0, 1'b0, 1);
    issue(1'b1, 1'b1, 1'b0, 5'd4, 32'd1028, 32'd0, 32'hDEAD_BEEF, 1'b0, 1);

    // Back-to-back ALU ops
    issue(1'b1, 1'b0, 1'b0, 5'd1, 32'd5, 32'd0, 32'd0, 1'b0, 0);
    issue(1'b1, 1'b0, 1'b0, 5'd2, 32'd6, 32'd0, 32'd0, 1'b0, 0);
    issue(1'b1, 1'b0, 1'b0, 5'd3, 32'd7, 32'd0, 32'd0, 1'b0, 0);

    // Faulting accesses
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'd1026, 32'h2222_2222, 32'd0, 1'b1, 1);
    issue(1'b1, 1'b1, 1'b0, 5'd6, 32'd1024, 32'd0, 32'h1111_1111, 1'b0, 1);
    issue(1'b1, 1'b1, 1'b0, 5'd7, 32'd2048, 32'd0, 32'd0, 1'b1, 1);
    issue(1'b1, 1'b1, 1'b0, 5'd8, 32'd1020, 32'd0, 32'd0, 1'b1, 1);

    // Last valid word
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'd2044, 32'h0000_0077, 32'd0, 1'b0, 1);
    issue(1'b1, 1'b1, 1'b0, 5'd9, 32'd2044, 32'd0, 32'h0000_0077, 1'b0, 1);

    // Reset during a store drops it
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'd1032, 32'h3333_3333, 32'd0, 1'b0, 1);
    idle(4);
    ev = 1'b1; wb_en = 1'b0; rd_en = 1'b0; wr_en = 1'b1; dest = '0;
    alu = 32'd1032; stv = 32'h4444_4444;
    @(posedge clk); #1;
    chk("rst_mid_stall", 32'(stall2), 32'd1);
    ev = 1'b0;
    #2 rst = 1'b0;
    #1 chk_zero("rst_mid_async");
    repeat (2) begin @(posedge clk); #1; end
    chk_zero("rst_mid_held");
    rst = 1'b1;
    idle(1);
    issue(1'b1, 1'b1, 1'b0, 5'd10, 32'd1032, 32'd0, 32'h3333_3333, 1'b0, 1);
    idle(4);

    // Latency 4: store and load flags together, store wins
    sel = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 5'd0, 32'd1036, 32'h5555_5555, 32'd0, 1'b0, 3);
    issue(1'b1, 1'b1, 1'b0, 5'd11, 32'd1036, 32'd0, 32'h5555_5555, 1'b0, 3);
    issue(1'b1, 1'b0, 1'b0, 5'd12, 32'd99, 32'd0, 32'd0, 1'b0, 0);
    idle(8);

    chk("drain_lat2", 32'(q2.size()), 32'd0);
    chk("drain_lat4", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
